// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg
//   Shared constants for the ALU arbiter slice: opcode encodings of the shared
//   ALU, the number of legal opcodes and the arbiter FSM state encoding.
//   No ports (package).
package alu_arbiter_pkg;

  localparam logic [3:0] ALU_OP_0 = 4'h0;
  localparam logic [3:0] ALU_OP_1 = 4'h1;
  localparam logic [3:0] ALU_OP_2 = 4'h2;
  localparam logic [3:0] ALU_OP_3 = 4'h3;
  localparam logic [3:0] ALU_OP_4 = 4'h4;
  localparam logic [3:0] ALU_OP_5 = 4'h5;
  localparam logic [3:0] ALU_OP_6 = 4'h6;
  localparam logic [3:0] ALU_OP_7 = 4'h7;
  localparam logic [3:0] ALU_OP_8 = 4'h8;
  localparam logic [3:0] ALU_OP_9 = 4'h9;
  localparam logic [3:0] ALU_OP_A = 4'hA;
  localparam logic [3:0] ALU_OP_B = 4'hB;

  localparam int NUM_OPS = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Bundles the requester, ALU and response signals of the ALU arbiter.
//   slave  : arbiter side (takes requests, drives ALU operands and response)
//   master : environment side (issue logic, ALU, response consumer)
//   Signals:
//     req_valid/req_ready   per-requester handshake (ready is one-hot)
//     req_op/req_a/req_b    packed per-requester opcode and operands
//     alu_ctrl/alu_a/alu_b  registered operands to the shared ALU
//     alu_result            ALU result, 2*DATA_W wide
//     rsp_valid/rsp_ready   response handshake
//     rsp_id/rsp_result     owner index and captured result
//     rsp_err               illegal-opcode flag
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*OP_W-1:0]   req_op;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [OP_W-1:0]           alu_ctrl;
  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [2*DATA_W-1:0]       alu_result;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [2*DATA_W-1:0]       rsp_result;
  logic                      rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
    input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: first asserted req bit searching from ptr
//   upward with wrap. The pointer register is owned by the instantiating block.
//   Ports:
//     req       in  NUM_REQ  request vector
//     ptr       in  ID_W     highest-priority index this cycle
//     grant     out NUM_REQ  one-hot grant (zero when no request)
//     grant_idx out ID_W     index of the granted bit
//     any       out 1        at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU among NUM_REQ requesters. Round-robin grant,
//   registered operands to the ALU, registered result returned on a single
//   response channel tagged with the requester index. One op in flight.
//   Optional macro ALU_ARB_OPCHK_EN: opcodes >= NUM_OPS are accepted but sent
//   to the ALU as 0 and answered with rsp_result=0, rsp_err=1. Without it the
//   opcode is forwarded unchecked and rsp_err is tied 0.
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  asynchronous active-high reset
//     bus  alu_arbiter_if.slave (requests, ALU operands/result, response)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a request; grants and latches operands on accept
//   ST_EXEC | ALU settling on registered operands; result captured at edge
//   ST_RESP | response held stable until rsp_ready
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 4,
  parameter int NUM_OPS = alu_arbiter_pkg::NUM_OPS
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  import alu_arbiter_pkg::*;

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e state_q, state_d;

  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     rr_ptr_next;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;

  logic [OP_W-1:0]     op_sel;
  logic [OP_W-1:0]     op_ld;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [2*DATA_W-1:0] res_ld;

  logic [OP_W-1:0]     alu_ctrl_q;
  logic [DATA_W-1:0]   alu_a_q;
  logic [DATA_W-1:0]   alu_b_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [2*DATA_W-1:0] rsp_result_q;

  logic accept;
  logic capture;
  logic release_rsp;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign op_sel = bus.req_op[int'(grant_idx)*OP_W +: OP_W];
  assign a_sel  = bus.req_a[int'(grant_idx)*DATA_W +: DATA_W];
  assign b_sel  = bus.req_b[int'(grant_idx)*DATA_W +: DATA_W];

  assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    accept        = 1'b0;
    capture       = 1'b0;
    release_rsp   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          bus.req_ready = grant_oh;
          accept        = 1'b1;
          state_d       = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          release_rsp = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand registers deliberately keep the last op after completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      alu_ctrl_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      if (accept) begin
        alu_ctrl_q <= op_ld;
        alu_a_q    <= a_sel;
        alu_b_q    <= b_sel;
        rsp_id_q   <= grant_idx;
        rr_ptr_q   <= rr_ptr_next;
      end
      if (capture) begin
        rsp_result_q <= res_ld;
        rsp_valid_q  <= 1'b1;
      end
      if (release_rsp) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  logic op_illegal;
  logic err_pend_q;
  logic rsp_err_q;

  assign op_illegal = (int'(op_sel) >= NUM_OPS);
  assign op_ld      = op_illegal ? '0 : op_sel;
  // Whatever the ALU returns for opcode 0 is discarded for an illegal op.
  assign res_ld     = err_pend_q ? '0 : bus.alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept)  err_pend_q <= op_illegal;
      if (capture) rsp_err_q  <= err_pend_q;
    end
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign op_ld       = op_sel;
  assign res_ld      = bus.alu_result;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.alu_ctrl   = alu_ctrl_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed bench for alu_arbiter with a behavioural stand-in for the shared
//   ALU driven from the registered operands. Build with ALU_ARB_OPCHK_EN to
//   exercise the illegal-opcode path.
module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;

  logic clk;
  logic rst;

  int vecs;
  int errs;

  logic [63:0] sweep_exp [12];

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] t;
    logic [63:0] r;
    t = 32'h0;
    case (op)
      4'h0: r = {32'h0, a} + {32'h0, b};
      4'h1: r = {32'h0, a} - {32'h0, b};
      4'h2: r = {32'h0, a & b};
      4'h3: r = {32'h0, a | b};
      4'h4: r = {32'h0, a ^ b};
      4'h5: r = {32'h0, a << b[4:0]};
      4'h6: r = {32'h0, a >> b[4:0]};
      4'h7: begin t = $signed(a) >>> b[4:0]; r = {32'h0, t}; end
      4'h8: r = {32'h0, a} * {32'h0, b};
      4'h9: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      4'hA: r = {63'h0, $signed(a) < $signed(b)};
      4'hB: r = {63'h0, a < b};
      default: r = 64'hDEAD_BEEF_DEAD_BEEF;
    endcase
    return r;
  endfunction

  assign bus.alu_result = alu_model(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    bus.req_op[i*OP_W +: OP_W]     = op;
    bus.req_a[i*DATA_W +: DATA_W]  = a;
    bus.req_b[i*DATA_W +: DATA_W]  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    vecs++;
    if ({bus.req_ready, bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id,
         bus.rsp_result, bus.rsp_err} !== '0) begin
      $display("FAIL reset_state: outputs not all zero (ready=%b ctrl=%h a=%h b=%h v=%b id=%0d res=%h err=%b)",
               bus.req_ready, bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id,
               bus.rsp_result, bus.rsp_err);
      errs++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 4'h0, 32'h7fff_ffff, 32'h7fff_ffff);
    bus.req_valid = 4'b0001;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0001) begin
      $display("FAIL single_ready: got %b want 0001", bus.req_ready); errs++;
    end
    tick();
    bus.req_valid = '0;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'h7fff_ffff) begin
      $display("FAIL single_exec: ready=%b rsp_valid=%b alu_a=%h want 0000 0 7fffffff",
               bus.req_ready, bus.rsp_valid, bus.alu_a); errs++;
    end
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 ||
        bus.rsp_result !== 64'h0000_0000_FFFF_FFFE) begin
      $display("FAIL single_rsp: v=%b id=%0d res=%h want 1 0 00000000fffffffe",
               bus.rsp_valid, bus.rsp_id, bus.rsp_result); errs++;
    end
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b0) begin
      $display("FAIL single_done: rsp_valid=%b want 0", bus.rsp_valid); errs++;
    end
  endtask

  // rr_ptr is 1 here; req2 is granted, then reset lands in EXEC.
  task automatic test_reset_mid_exec();
    set_req(2, 4'h3, 32'h1234_5678, 32'h0000_0001);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    vecs++;
    if ({bus.req_ready, bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.rsp_valid, bus.rsp_id,
         bus.rsp_result, bus.rsp_err} !== '0) begin
      $display("FAIL reset_mid_exec: outputs not zero (ctrl=%h a=%h v=%b id=%0d)",
               bus.alu_ctrl, bus.alu_a, bus.rsp_valid, bus.rsp_id); errs++;
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b0) begin
      $display("FAIL reset_no_rsp: rsp_valid=%b want 0", bus.rsp_valid); errs++;
    end
    // All valid from a reset pointer must pick 0; dropping before the edge leaves no grant.
    bus.req_valid = 4'b1111;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0001) begin
      $display("FAIL reset_ptr: ready=%b want 0001", bus.req_ready); errs++;
    end
    bus.req_valid = '0;
    tick();
    vecs++;
    if (bus.req_ready !== 4'b0000 || bus.alu_ctrl !== 4'h0) begin
      $display("FAIL drop_before_grant: ready=%b ctrl=%h want 0000 0", bus.req_ready,
               bus.alu_ctrl); errs++;
    end
  endtask

  task automatic test_fairness();
    int exp_id;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 4'h0, 32'(i + 1), 32'h10);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      exp_id = k % 4;
      #1;
      vecs++;
      if (bus.req_ready !== 4'(1 << exp_id)) begin
        $display("FAIL fair_grant[%0d]: ready=%b want %b", k, bus.req_ready, 4'(1 << exp_id));
        errs++;
      end
      tick();
      tick();
      vecs++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(exp_id) ||
          bus.rsp_result !== 64'(exp_id + 32'h11)) begin
        $display("FAIL fair_rsp[%0d]: v=%b id=%0d res=%h want 1 %0d %h", k, bus.rsp_valid,
                 bus.rsp_id, bus.rsp_result, exp_id, 64'(exp_id + 32'h11)); errs++;
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  // rr_ptr is 2 here: req3 wins over req1, then req1 follows right after the handshake.
  task automatic test_back_to_back();
    set_req(3, 4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF);
    set_req(1, 4'h0, 32'h5, 32'h6);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1010;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b1000) begin
      $display("FAIL bp_grant: ready=%b want 1000", bus.req_ready); errs++;
    end
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      vecs++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd3 ||
          bus.rsp_result !== 64'h0000_0000_00F0_1234 || bus.req_ready !== 4'b0000) begin
        $display("FAIL bp_hold[%0d]: v=%b id=%0d res=%h ready=%b want 1 3 0000000000f01234 0000",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.req_ready); errs++;
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin
      $display("FAIL bp_release: v=%b ready=%b want 0 0010", bus.rsp_valid, bus.req_ready);
      errs++;
    end
    tick();
    bus.req_valid = '0;
    tick();
    vecs++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_result !== 64'd11) begin
      $display("FAIL bp_next: v=%b id=%0d res=%h want 1 1 000000000000000b", bus.rsp_valid,
               bus.rsp_id, bus.rsp_result); errs++;
    end
    tick();
  endtask

  task automatic test_sweep();
    sweep_exp[0]  = 64'h0000_0001_FFFF_FFFE;
    sweep_exp[1]  = 64'h0000_0000_0000_0000;
    sweep_exp[2]  = 64'h0000_0000_FFFF_FFFF;
    sweep_exp[3]  = 64'h0000_0000_FFFF_FFFF;
    sweep_exp[4]  = 64'h0000_0000_0000_0000;
    sweep_exp[5]  = 64'h0000_0000_8000_0000;
    sweep_exp[6]  = 64'h0000_0000_0000_0001;
    sweep_exp[7]  = 64'h0000_0000_FFFF_FFFF;
    sweep_exp[8]  = 64'hFFFF_FFFE_0000_0001;
    sweep_exp[9]  = 64'h0000_0000_0000_0001;
    sweep_exp[10] = 64'h0000_0000_0000_0000;
    sweep_exp[11] = 64'h0000_0000_0000_0000;
    bus.rsp_ready = 1'b1;
    for (int op = 0; op < 12; op++) begin
      set_req(2, 4'(op), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bus.req_valid = 4'b0100;
      #1;
      vecs++;
      if (bus.req_ready !== 4'b0100) begin
        $display("FAIL sweep_grant[%0d]: ready=%b want 0100", op, bus.req_ready); errs++;
      end
      tick();
      bus.req_valid = '0;
      vecs++;
      if (bus.alu_ctrl !== 4'(op)) begin
        $display("FAIL sweep_ctrl[%0d]: alu_ctrl=%h want %h", op, bus.alu_ctrl, 4'(op)); errs++;
      end
      tick();
      vecs++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_result !== sweep_exp[op] ||
          bus.rsp_err !== 1'b0) begin
        $display("FAIL sweep_rsp[%0d]: v=%b id=%0d res=%h err=%b want 1 2 %h 0", op,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_err, sweep_exp[op]);
        errs++;
      end
      tick();
    end
  endtask

  task automatic test_opchk();
    set_req(2, 4'hC, 32'h0000_0003, 32'h0000_0004);
    bus.req_valid = 4'b0100;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0100) begin
      $display("FAIL opchk_grant: ready=%b want 0100", bus.req_ready); errs++;
    end
    tick();
    bus.req_valid = '0;
    vecs++;
`ifdef ALU_ARB_OPCHK_EN
    if (bus.alu_ctrl !== 4'h0) begin
      $display("FAIL opchk_ctrl: alu_ctrl=%h want 0", bus.alu_ctrl); errs++;
    end
`else
    if (bus.alu_ctrl !== 4'hC) begin
      $display("FAIL opchk_ctrl: alu_ctrl=%h want c", bus.alu_ctrl); errs++;
    end
`endif
    tick();
    vecs++;
`ifdef ALU_ARB_OPCHK_EN
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_result !== 64'h0) begin
      $display("FAIL opchk_rsp: v=%b err=%b res=%h want 1 1 0", bus.rsp_valid, bus.rsp_err,
               bus.rsp_result); errs++;
    end
`else
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_result !== 64'hDEAD_BEEF_DEAD_BEEF) begin
      $display("FAIL opchk_rsp: v=%b err=%b res=%h want 1 0 deadbeefdeadbeef", bus.rsp_valid,
               bus.rsp_err, bus.rsp_result); errs++;
    end
`endif
    tick();
    // A legal op right after must clear the error flag again.
    set_req(2, 4'h4, 32'h0000_00FF, 32'h0000_000F);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    tick();
    vecs++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_result !== 64'h0000_0000_0000_00F0) begin
      $display("FAIL opchk_clear: err=%b res=%h want 0 00000000000000f0", bus.rsp_err,
               bus.rsp_result); errs++;
    end
    tick();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single();
    test_reset_mid_exec();
    test_fairness();
    test_back_to_back();
    test_sweep();
    test_opchk();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
